// File: rtl/debounced_command_input.sv
// debounced_command_input: key synchronisers, per-key stable-level debouncers,
// press-edge pulses and a single-entry HIT/STAND command register with valid/ack.
// Optional build macro: DROP_COUNT_EN adds o_drop_count, a saturating count of
// HIT/STAND presses that were discarded (command pending, or not this player's turn).

`ifndef gameCommand
`define gameCommand [1:0]
`endif

// Purpose: turn bouncy active-low KEY pins into one clean command per physical press.
// Latency: 2 cycles sync + DEBOUNCE_CYCLES debounce + 1 cycle press pulse + 1 cycle to o_cmd_valid.
// Backpressure: o_command is held until i_cmd_ack; HIT/STAND presses arriving meanwhile are dropped.
module debounced_command_input #(
    parameter int NUM_KEYS        = 3,
    parameter int DEBOUNCE_CYCLES = 10000,
    parameter int CNT_W           = 14
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [NUM_KEYS-1:0] i_KEY,
    input  logic                i_turnIndicator,
    input  logic                i_cmd_ack,
    output logic [NUM_KEYS-1:0] o_key_press,
    output logic [NUM_KEYS-1:0] o_key_level,
    output logic                o_dealButtonPushed,
    output logic                o_cmd_valid,
    output logic `gameCommand   o_command
`ifdef DROP_COUNT_EN
    ,
    output logic [7:0]          o_drop_count
`endif
);

    // Command encodings shared with the game FSM.
    localparam logic [1:0] COMMAND_NONE  = 2'd0;
    localparam logic [1:0] COMMAND_HIT   = 2'd1;
    localparam logic [1:0] COMMAND_STAND = 2'd2;

    // Key roles.
    localparam int KEY_HIT   = 0;
    localparam int KEY_STAND = 1;
    localparam int KEY_DEAL  = 2;

    // Terminal count: a level change is accepted on the DEBOUNCE_CYCLES-th
    // consecutive cycle in which the synchronised key differs from the level.
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Synchroniser: raw pin levels, released (1) out of reset.
    // ------------------------------------------------------------------
    logic [NUM_KEYS-1:0] sync1_q, sync1_d;
    logic [NUM_KEYS-1:0] sync2_q, sync2_d;
    logic [NUM_KEYS-1:0] key_pushed;   // synchronised, 1 = pushed

    // Two-stage shift of the raw pins into the clock domain.
    always_comb begin
        sync1_d    = i_KEY;
        sync2_d    = sync1_q;
        key_pushed = ~sync2_q;
    end

    // Synchroniser registers; reset to the released pin level.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    // ------------------------------------------------------------------
    // Debouncer: one stability counter and one accepted level per key.
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]    cnt_q [NUM_KEYS];
    logic [CNT_W-1:0]    cnt_d [NUM_KEYS];
    logic [NUM_KEYS-1:0] level_q, level_d;

    // Count consecutive disagreeing samples; accept the new level at terminal count.
    always_comb begin
        level_d = level_q;
        for (int k = 0; k < NUM_KEYS; k++) begin
            cnt_d[k] = '0;
            if (key_pushed[k] != level_q[k]) begin
                if (cnt_q[k] >= CNT_MAX) begin
                    // Stable long enough: take the new level and restart.
                    level_d[k] = key_pushed[k];
                    cnt_d[k]   = '0;
                end else begin
                    cnt_d[k] = cnt_q[k] + CNT_W'(1);
                end
            end
        end
    end

    // Debounce state registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            level_q <= '0;
            for (int k = 0; k < NUM_KEYS; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            level_q <= level_d;
            for (int k = 0; k < NUM_KEYS; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    // ------------------------------------------------------------------
    // Press detection: registered rising edge of the debounced level.
    // ------------------------------------------------------------------
    logic [NUM_KEYS-1:0] level_prev_q, level_prev_d;
    logic [NUM_KEYS-1:0] press_q, press_d;

    // A press is a 0->1 step of the accepted level; releases are ignored.
    always_comb begin
        level_prev_d = level_q;
        press_d      = level_q & ~level_prev_q;
    end

    // Edge detector registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            level_prev_q <= '0;
            press_q      <= '0;
        end else begin
            level_prev_q <= level_prev_d;
            press_q      <= press_d;
        end
    end

    // ------------------------------------------------------------------
    // Command FSM: IDLE accepts one HIT/STAND, PEND holds it until ack.
    // ------------------------------------------------------------------
    state_t     state_q, state_d;
    logic [1:0] cmd_q, cmd_d;

    // State and command registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            cmd_q   <= COMMAND_NONE;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
        end
    end

    // Next state: STAND has priority over HIT; off-turn and pending-time presses are not queued.
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        case (state_q)
            ST_IDLE: begin
                if (i_turnIndicator && press_q[KEY_STAND]) begin
                    state_d = ST_PEND;
                    cmd_d   = COMMAND_STAND;
                end else if (i_turnIndicator && press_q[KEY_HIT]) begin
                    state_d = ST_PEND;
                    cmd_d   = COMMAND_HIT;
                end
            end
            ST_PEND: begin
                // Turn loss does not cancel; only the consumer's ack does.
                if (i_cmd_ack) begin
                    state_d = ST_IDLE;
                    cmd_d   = COMMAND_NONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cmd_d   = COMMAND_NONE;
            end
        endcase
    end

    // Outputs: command is only presented while pending.
    always_comb begin
        o_cmd_valid        = (state_q == ST_PEND);
        o_command          = (state_q == ST_PEND) ? cmd_q : COMMAND_NONE;
        o_key_press        = press_q;
        o_key_level        = level_q;
        o_dealButtonPushed = press_q[KEY_DEAL];
    end

`ifdef DROP_COUNT_EN
    // ------------------------------------------------------------------
    // Dropped-press counter (saturating at 255).
    // ------------------------------------------------------------------
    logic [7:0] drop_cnt_q, drop_cnt_d;
    logic [1:0] drop_mask;
    logic [1:0] drop_inc;
    logic [8:0] drop_sum;

    // Every HIT/STAND press seen while pending or off-turn is lost; count each one.
    always_comb begin
        drop_mask  = {press_q[KEY_STAND], press_q[KEY_HIT]}
                   & {2{(state_q == ST_PEND) || !i_turnIndicator}};
        drop_inc   = {1'b0, drop_mask[0]} + {1'b0, drop_mask[1]};
        drop_sum   = {1'b0, drop_cnt_q} + {7'd0, drop_inc};
        drop_cnt_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end

    // Drop counter register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign o_drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_debounced_command_input.sv
module tb_debounced_command_input;

    localparam int NK = 3;
    localparam int DB = 4;
    localparam int CW = 4;

    localparam logic [1:0] C_NONE  = 2'd0;
    localparam logic [1:0] C_HIT   = 2'd1;
    localparam logic [1:0] C_STAND = 2'd2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [NK-1:0] key;
    logic          turn;
    logic          ack;
    logic [NK-1:0] key_press;
    logic [NK-1:0] key_level;
    logic          deal;
    logic          cmd_valid;
    logic [1:0]    command;
`ifdef DROP_COUNT_EN
    logic [7:0]    drop_count;
`endif

    debounced_command_input #(
        .NUM_KEYS        (NK),
        .DEBOUNCE_CYCLES (DB),
        .CNT_W           (CW)
    ) dut (
        .i_clk              (clk),
        .i_reset            (rst),
        .i_KEY              (key),
        .i_turnIndicator    (turn),
        .i_cmd_ack          (ack),
        .o_key_press        (key_press),
        .o_key_level        (key_level),
        .o_dealButtonPushed (deal),
        .o_cmd_valid        (cmd_valid),
        .o_command          (command)
`ifdef DROP_COUNT_EN
        ,
        .o_drop_count       (drop_count)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: pin delay line, window of the last DB synchronised
    // samples per key, and a single pending-command slot.
    // ------------------------------------------------------------------
    logic [NK-1:0] m_sync1, m_sync2;
    logic [DB-1:0] m_win [NK];
    logic [NK-1:0] m_lvl, m_rose, m_press;
    bit            m_pend;
    logic [1:0]    m_cmd;
    int            m_drops;
    bit            m_init = 0;

    task automatic model_step();
        int   dropped;
        logic s;
        dropped = 0;
        if (rst) begin
            m_sync1 = '1;
            m_sync2 = '1;
            for (int k = 0; k < NK; k++) m_win[k] = '0;
            m_lvl   = '0;
            m_rose  = '0;
            m_press = '0;
            m_pend  = 0;
            m_cmd   = C_NONE;
            m_drops = 0;
            m_init  = 1;
        end else begin
            if (m_pend) begin
                dropped = int'(m_press[0]) + int'(m_press[1]);
                if (ack) begin
                    m_pend = 0;
                    m_cmd  = C_NONE;
                end
            end else if (!turn) begin
                dropped = int'(m_press[0]) + int'(m_press[1]);
            end else if (m_press[1]) begin
                m_pend = 1;
                m_cmd  = C_STAND;
            end else if (m_press[0]) begin
                m_pend = 1;
                m_cmd  = C_HIT;
            end
            m_drops = (m_drops + dropped > 255) ? 255 : m_drops + dropped;
            m_press = m_rose;
            for (int k = 0; k < NK; k++) begin
                s         = ~m_sync2[k];
                m_win[k]  = {m_win[k][DB-2:0], s};
                m_rose[k] = 1'b0;
                // New level once the whole window agrees on the opposite value.
                if (m_win[k] == {DB{~m_lvl[k]}}) begin
                    m_lvl[k]  = ~m_lvl[k];
                    m_rose[k] = m_lvl[k];
                end
            end
            m_sync2 = m_sync1;
            m_sync1 = key;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            model_step();
        end
    end

    // Per-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (m_init) begin
                check("key_level", 32'(key_level), 32'(m_lvl));
                check("key_press", 32'(key_press), 32'(m_press));
                check("deal_pulse", 32'(deal), 32'(m_press[2]));
                check("cmd_valid", 32'(cmd_valid), 32'(m_pend));
                check("command", 32'(command), 32'(m_pend ? m_cmd : C_NONE));
`ifdef DROP_COUNT_EN
                check("drop_count", 32'(drop_count), 32'(m_drops));
`endif
            end
        end
    end

    // Event monitors for the directed literal checks.
    int press0_cnt = 0, press0_cyc = 0;
    int rise_cnt = 0, rise_cyc = 0;
    int deal_cnt = 0;
    logic valid_prev = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            if (key_press[0] === 1'b1) begin
                press0_cnt++;
                press0_cyc = cyc;
            end
            if (cmd_valid === 1'b1 && valid_prev !== 1'b1) begin
                rise_cnt++;
                rise_cyc = cyc;
            end
            valid_prev = cmd_valid;
            if (deal === 1'b1) deal_cnt++;
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_key(input int k, input int n);
        key[k] = 1'b0;
        step(n);
        key[k] = 1'b1;
        step(n);
    endtask

    task automatic ack_pulse();
        ack = 1'b1;
        step(1);
        ack = 1'b0;
    endtask

    int first;
    int base_press, base_rise, base_deal;
    int chg;

    initial begin
        rst  = 1'b1;
        key  = '1;
        turn = 1'b0;
        ack  = 1'b0;
        step(3);
        rst = 1'b0;

        // Idle after reset.
        step(20);
        check("idle_level", 32'(key_level), 32'd0);
        check("idle_valid", 32'(cmd_valid), 32'd0);
        check("idle_command", 32'(command), 32'(C_NONE));
        check("idle_no_press", 32'(press0_cnt), 32'd0);

        // Bounce: three low samples are one short of acceptance.
        turn   = 1'b1;
        key[0] = 1'b0;
        step(3);
        key[0] = 1'b1;
        step(12);
        check("bounce_no_press", 32'(press0_cnt), 32'd0);
        check("bounce_no_valid", 32'(rise_cnt), 32'd0);

        // Clean hold: press six cycles after the first low sample, HIT one later.
        base_press = press0_cnt;
        key[0] = 1'b0;
        first  = cyc + 1;
        step(10);
        key[0] = 1'b1;
        check("hold_one_press", 32'(press0_cnt), 32'(base_press + 1));
        check("hold_press_latency", 32'(press0_cyc - first), 32'd6);
        check("hold_valid_latency", 32'(rise_cyc - press0_cyc), 32'd1);
        check("hold_cmd_hit", 32'(command), 32'(C_HIT));
        step(3);
        check("held_until_ack", 32'(cmd_valid), 32'd1);
        ack_pulse();
        check("ack_valid_low", 32'(cmd_valid), 32'd0);
        check("ack_cmd_none", 32'(command), 32'(C_NONE));
        step(10);

        // Same-cycle HIT+STAND: STAND wins and no HIT trails it.
        base_rise = rise_cnt;
        key[1:0] = 2'b00;
        step(10);
        key = '1;
        check("dual_valid", 32'(cmd_valid), 32'd1);
        check("dual_stand", 32'(command), 32'(C_STAND));
        ack_pulse();
        check("dual_ack_none", 32'(command), 32'(C_NONE));
        step(15);
        check("dual_no_hit", 32'(rise_cnt), 32'(base_rise + 1));

        // Deal off-turn: one pulse, no command.
        turn      = 1'b0;
        base_deal = deal_cnt;
        base_rise = rise_cnt;
        press_key(2, 10);
        check("deal_pulse_once", 32'(deal_cnt), 32'(base_deal + 1));
        check("deal_no_valid", 32'(rise_cnt), 32'(base_rise));

`ifdef DROP_COUNT_EN
        // Two presses dropped while pending, one dropped off-turn.
        turn = 1'b1;
        press_key(0, 8);
        press_key(0, 8);
        press_key(0, 8);
        ack_pulse();
        turn = 1'b0;
        press_key(0, 8);
        check("drop_count_3", 32'(drop_count), 32'd3);
`endif

        // Reset while pending discards the command.
        turn = 1'b1;
        press_key(0, 8);
        check("pend_before_reset", 32'(cmd_valid), 32'd1);
        rst = 1'b1;
        step(1);
        check("reset_valid", 32'(cmd_valid), 32'd0);
`ifdef DROP_COUNT_EN
        check("reset_drop_count", 32'(drop_count), 32'd0);
`endif
        rst = 1'b0;
        step(5);

        // Randomised phase: bouncy keys, wandering turn, random ack, rare reset.
        chg = 6;
        for (int i = 0; i < 4000; i++) begin
            if (i % 250 == 0) chg = $urandom_range(2, 14);
            for (int k = 0; k < NK; k++) begin
                if ($urandom_range(0, chg - 1) == 0) key[k] = ~key[k];
            end
            if ($urandom_range(0, 39) == 0) turn = ~turn;
            ack = ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 599) == 0);
            step(1);
        end
        rst = 1'b0;
        ack = 1'b0;
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
